// File: rtl/alu_sequencer.sv
// alu_sequencer
// -------------
// Command-driven controller for the 8-bit ALU datapath. A command arrives on a
// valid/ready channel. The sequencer then loads the operands into the ALU's
// operand register stage, selects the requested function for one execute
// cycle, and captures the result. The result goes back on a valid/ready
// response channel together with an error flag.
//
// Optional feature macro: ALU_SEQ_CHAIN_EN
//   defined   - cmd_chain is honoured; a result accumulator feeds operand A
//   undefined - cmd_chain is ignored and operand A always comes from cmd_a
//
// Ports
//   clk          in   sole clock, rising edge
//   rst          in   asynchronous reset, active low
//   on           in   enable, only looked at in OFF and READY
//   cmd_valid    in   command handshake valid
//   cmd_ready    out  command handshake ready (high only in READY)
//   cmd_op       in   0 AND, 1 OR, 2 NOT, 3 XOR, 4 ADD, 5 SUB, 6 MULT, 7 illegal
//   cmd_chain    in   use the accumulator as operand A
//   cmd_a/cmd_b  in   operands
//   alu_in_sel   out  one-hot {persist, load, reset} for the ALU operand muxes
//   alu_num1/2   out  operands presented to the ALU
//   alu_out_sel  out  one-hot function select, MSB = AND, LSB = MULT
//   alu_result   in   ALU result
//   alu_overflow in   ALU overflow flag (only meaningful for MULT here)
//   rsp_valid    out  response handshake valid
//   rsp_ready    in   response handshake ready
//   rsp_data     out  captured result
//   rsp_error    out  MULT overflow or illegal opcode
//   op_count     out  completed responses, wraps at 8 bits

module alu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       on,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic       cmd_chain,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic [2:0] alu_in_sel,
  output logic [7:0] alu_num1,
  output logic [7:0] alu_num2,
  output logic [6:0] alu_out_sel,
  input  logic [7:0] alu_result,
  input  logic       alu_overflow,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_error,
  output logic [7:0] op_count
);

  typedef enum logic [2:0] {
    OFF,
    READY,
    LOAD,
    EXEC,
    RESP,
    ERROR
  } state_t;

  localparam logic [2:0] SEL_PERSIST = 3'b100;
  localparam logic [2:0] SEL_LOAD    = 3'b010;
  localparam logic [2:0] SEL_RESET   = 3'b001;

  localparam logic [2:0] OP_MULT     = 3'd6;
  localparam logic [2:0] OP_ILLEGAL  = 3'd7;

  state_t     state_q;
  logic [2:0] op_q;
  logic       cmdReady_q;
  logic       rspValid_q;
  logic [7:0] rspData_q;
  logic       rspError_q;
  logic [2:0] inSel_q;
  logic [6:0] outSel_q;
  logic [7:0] num1_q;
  logic [7:0] num2_q;
  logic [7:0] opCount_q;
  logic [7:0] num1_d;

`ifdef ALU_SEQ_CHAIN_EN
  logic [7:0] acc_q;

  // Operand A for the load phase: a chained command takes the previous
  // result instead of cmd_a. The accumulator only moves on EXEC exit or in
  // ERROR, so choosing at accept time gives the same value LOAD would see.
  assign num1_d = cmd_chain ? acc_q : cmd_a;

  // Accumulator tracks every captured ALU result. It is cleared in ERROR so
  // that a chain started after a multiply overflow begins from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= 8'h00;
    end else if (state_q == EXEC) begin
      acc_q <= alu_result;
    end else if (state_q == ERROR) begin
      acc_q <= 8'h00;
    end
  end
`else
  logic unusedChain;

  // Without chaining, operand A is always the command's own A operand.
  assign num1_d      = cmd_a;
  assign unusedChain = cmd_chain;
`endif

  // Main sequencer. Every output is a register that is written on the
  // transition into the state that owns it. Nothing on the outputs depends
  // combinationally on cmd_valid or rsp_ready. An illegal opcode skips the
  // ALU entirely and answers in the very next cycle. A multiply overflow
  // makes an extra pass through ERROR to reset the ALU operand registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= OFF;
      op_q       <= 3'd0;
      cmdReady_q <= 1'b0;
      rspValid_q <= 1'b0;
      rspData_q  <= 8'h00;
      rspError_q <= 1'b0;
      inSel_q    <= SEL_RESET;
      outSel_q   <= 7'b0000000;
      num1_q     <= 8'h00;
      num2_q     <= 8'h00;
      opCount_q  <= 8'h00;
    end else begin
      case (state_q)
        OFF: begin
          if (on) begin
            state_q    <= READY;
            cmdReady_q <= 1'b1;
            inSel_q    <= SEL_PERSIST;
          end
        end
        READY: begin
          if (!on) begin
            state_q    <= OFF;
            cmdReady_q <= 1'b0;
            inSel_q    <= SEL_RESET;
          end else if (cmd_valid) begin
            cmdReady_q <= 1'b0;
            op_q       <= cmd_op;
            if (cmd_op == OP_ILLEGAL) begin
              state_q    <= RESP;
              rspValid_q <= 1'b1;
              rspData_q  <= 8'h00;
              rspError_q <= 1'b1;
            end else begin
              state_q <= LOAD;
              inSel_q <= SEL_LOAD;
              num1_q  <= num1_d;
              num2_q  <= cmd_b;
            end
          end
        end
        LOAD: begin
          state_q  <= EXEC;
          inSel_q  <= SEL_PERSIST;
          outSel_q <= 7'b1000000 >> op_q;
        end
        EXEC: begin
          state_q    <= RESP;
          outSel_q   <= 7'b0000000;
          rspValid_q <= 1'b1;
          rspData_q  <= alu_result;
          rspError_q <= alu_overflow && (op_q == OP_MULT);
        end
        RESP: begin
          if (rsp_ready) begin
            rspValid_q <= 1'b0;
            opCount_q  <= opCount_q + 8'd1;
            if (rspError_q && (op_q == OP_MULT)) begin
              state_q <= ERROR;
              inSel_q <= SEL_RESET;
            end else begin
              state_q    <= READY;
              cmdReady_q <= 1'b1;
            end
          end
        end
        ERROR: begin
          state_q    <= READY;
          cmdReady_q <= 1'b1;
          inSel_q    <= SEL_PERSIST;
        end
        default: begin
          state_q <= OFF;
        end
      endcase
    end
  end

  assign cmd_ready   = cmdReady_q;
  assign rsp_valid   = rspValid_q;
  assign rsp_data    = rspData_q;
  assign rsp_error   = rspError_q;
  assign alu_in_sel  = inSel_q;
  assign alu_out_sel = outSel_q;
  assign alu_num1    = num1_q;
  assign alu_num2    = num2_q;
  assign op_count    = opCount_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
// ----------------
// Bench for alu_sequencer. A behavioural stand-in for the 8-bit ALU answers
// the sequencer's select and operand lines. A reference model computes each
// response from the opcode rules with plain integer arithmetic. That model
// also keeps its own accumulator and response counter. Works with or without
// ALU_SEQ_CHAIN_EN defined.

module tb_alu_sequencer;

  logic       clk;
  logic       rst;
  logic       on;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic       cmd_chain;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [2:0] alu_in_sel;
  logic [7:0] alu_num1;
  logic [7:0] alu_num2;
  logic [6:0] alu_out_sel;
  logic [7:0] alu_result;
  logic       alu_overflow;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_error;
  logic [7:0] op_count;

`ifdef ALU_SEQ_CHAIN_EN
  localparam bit CHAIN_ON = 1'b1;
`else
  localparam bit CHAIN_ON = 1'b0;
`endif

  int         testCount = 0;
  int         failCount = 0;
  logic [7:0] modelAcc = 8'h00;
  logic [7:0] modelCount = 8'h00;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] expData;
    logic       expErr;
  } vec_t;

  vec_t vecs[11];

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .on           (on),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_chain    (cmd_chain),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .alu_in_sel   (alu_in_sel),
    .alu_num1     (alu_num1),
    .alu_num2     (alu_num2),
    .alu_out_sel  (alu_out_sel),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_error    (rsp_error),
    .op_count     (op_count)
  );

  // Stand-in for the ALU datapath: decodes the one-hot output select. ADD
  // also raises overflow on carry, which the sequencer must ignore.
  logic [15:0] product;
  logic [8:0]  sum;
  always_comb begin
    product      = 16'(alu_num1) * 16'(alu_num2);
    sum          = 9'(alu_num1) + 9'(alu_num2);
    alu_result   = 8'h00;
    alu_overflow = 1'b0;
    case (alu_out_sel)
      7'b1000000: alu_result = alu_num1 & alu_num2;
      7'b0100000: alu_result = alu_num1 | alu_num2;
      7'b0010000: alu_result = ~alu_num1;
      7'b0001000: alu_result = alu_num1 ^ alu_num2;
      7'b0000100: begin
        alu_result   = sum[7:0];
        alu_overflow = sum[8];
      end
      7'b0000010: alu_result = alu_num1 - alu_num2;
      7'b0000001: begin
        alu_result   = product[7:0];
        alu_overflow = |product[15:8];
      end
      default: ;
    endcase
  end

  // Watchdog so the run always ends, even if the sequencer locks up.
  initial begin
    #2000000;
    failCount++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  // One comparison: counts it, and reports any difference.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Waits (bounded) for cmd_ready at a falling edge.
  task automatic waitReady(input string name);
    int waited;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput(name, 32'(cmd_ready), 32'd1);
  endtask

  // Checks every output against its reset value.
  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    checkOutput({tag, "_rsp_error"}, 32'(rsp_error), 32'd0);
    checkOutput({tag, "_in_sel"}, 32'(alu_in_sel), 32'h1);
    checkOutput({tag, "_out_sel"}, 32'(alu_out_sel), 32'd0);
    checkOutput({tag, "_num1"}, 32'(alu_num1), 32'd0);
    checkOutput({tag, "_num2"}, 32'(alu_num2), 32'd0);
    checkOutput({tag, "_op_count"}, 32'(op_count), 32'd0);
  endtask

  // Sends one command and follows it through every phase. The model's
  // expectations are checked at each step. rsp_ready is held low for
  // holdCycles extra cycles. Returns the response that was seen.
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic chain, input int holdCycles,
                               output logic [7:0] gotData, output logic gotErr);
    int         x;
    int         y;
    int         raw;
    logic [7:0] expData;
    logic       expErr;
    logic [6:0] expSel;

    x      = (CHAIN_ON && chain) ? int'(modelAcc) : int'(a);
    y      = int'(b);
    expErr = 1'b0;
    case (op)
      3'd0: raw = x & y;
      3'd1: raw = x | y;
      3'd2: raw = 255 - x;
      3'd3: raw = x ^ y;
      3'd4: raw = x + y;
      3'd5: raw = x - y + 256;
      3'd6: begin
        raw    = x * y;
        expErr = (raw > 255);
      end
      default: begin
        raw    = 0;
        expErr = 1'b1;
      end
    endcase
    expData = 8'(raw % 256);
    expSel  = 7'(1 << (6 - int'(op)));

    waitReady("cmd_ready_wait");
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_chain = chain;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;

    if (op == 3'd7) begin
      checkOutput("illegal_rsp_latency", 32'(rsp_valid), 32'd1);
    end else begin
      checkOutput("load_in_sel", 32'(alu_in_sel), 32'h2);
      checkOutput("load_num1", 32'(alu_num1), 32'(x % 256));
      checkOutput("load_num2", 32'(alu_num2), 32'(b));
      checkOutput("load_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("load_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      checkOutput("exec_in_sel", 32'(alu_in_sel), 32'h4);
      checkOutput("exec_out_sel", 32'(alu_out_sel), 32'(expSel));
      checkOutput("exec_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      checkOutput("rsp_latency", 32'(rsp_valid), 32'd1);
    end
    checkOutput("rsp_data", 32'(rsp_data), 32'(expData));
    checkOutput("rsp_error", 32'(rsp_error), 32'(expErr));
    checkOutput("rsp_out_sel", 32'(alu_out_sel), 32'd0);
    gotData = rsp_data;
    gotErr  = rsp_error;

    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold_rsp_data", 32'(rsp_data), 32'(expData));
      checkOutput("hold_op_count", 32'(op_count), 32'(modelCount));
    end

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready  = 1'b0;
    modelCount = modelCount + 8'd1;
    checkOutput("post_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("post_op_count", 32'(op_count), 32'(modelCount));

    if (op == 3'd6 && expErr) begin
      checkOutput("error_in_sel", 32'(alu_in_sel), 32'h1);
      checkOutput("error_cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      checkOutput("after_error_cmd_ready", 32'(cmd_ready), 32'd1);
    end else begin
      checkOutput("post_cmd_ready", 32'(cmd_ready), 32'd1);
    end

    if (op != 3'd7) begin
      modelAcc = expErr ? 8'h00 : expData;
    end
  endtask

  // Test sequence: reset, table vectors, multi-cycle corners, random
  // traffic, reset during EXEC, then op_count wrap.
  initial begin
    logic [7:0] gotData;
    logic       gotErr;
    logic [7:0] countBefore;

    vecs[0]  = '{3'd4, 8'h12, 8'h34, 8'h46, 1'b0};
    vecs[1]  = '{3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0};
    vecs[2]  = '{3'd1, 8'hF0, 8'h0F, 8'hFF, 1'b0};
    vecs[3]  = '{3'd2, 8'h5A, 8'h00, 8'hA5, 1'b0};
    vecs[4]  = '{3'd3, 8'hAA, 8'hFF, 8'h55, 1'b0};
    vecs[5]  = '{3'd5, 8'h05, 8'h0A, 8'hFB, 1'b0};
    vecs[6]  = '{3'd6, 8'h0F, 8'h11, 8'hFF, 1'b0};
    vecs[7]  = '{3'd6, 8'h10, 8'h10, 8'h00, 1'b1};
    vecs[8]  = '{3'd7, 8'h12, 8'h34, 8'h00, 1'b1};
    vecs[9]  = '{3'd4, 8'hFF, 8'h02, 8'h01, 1'b0};
    vecs[10] = '{3'd5, 8'h80, 8'h01, 8'h7F, 1'b0};

    rst       = 1'b0;
    on        = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_chain = 1'b0;
    cmd_a     = 8'h00;
    cmd_b     = 8'h00;
    rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkResetValues("off_idle");

    on = 1'b1;
    @(negedge clk);
    checkOutput("on_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 0, gotData, gotErr);
      checkOutput($sformatf("vec%0d_data", i), 32'(gotData), 32'(vecs[i].expData));
      checkOutput($sformatf("vec%0d_err", i), 32'(gotErr), 32'(vecs[i].expErr));
    end

    applyStimulus(3'd4, 8'h05, 8'h03, 1'b0, 0, gotData, gotErr);
    checkOutput("chain_add", 32'(gotData), 32'h08);
    applyStimulus(3'd5, 8'h20, 8'h0A, 1'b1, 0, gotData, gotErr);
    checkOutput("chain_sub", 32'(gotData), CHAIN_ON ? 32'hFE : 32'h16);

    applyStimulus(3'd6, 8'h10, 8'h10, 1'b0, 0, gotData, gotErr);
    checkOutput("mult_ovf_err", 32'(gotErr), 32'd1);
    applyStimulus(3'd4, 8'h33, 8'h01, 1'b1, 0, gotData, gotErr);
    checkOutput("chain_after_error", 32'(gotData), CHAIN_ON ? 32'h01 : 32'h34);

    countBefore = op_count;
    applyStimulus(3'd1, 8'h0C, 8'h30, 1'b0, 4, gotData, gotErr);
    checkOutput("hold_count_once", 32'(op_count), 32'(countBefore + 8'd1));
    checkOutput("hold_data", 32'(gotData), 32'h3C);

    applyStimulus(3'd7, 8'hAB, 8'hCD, 1'b0, 1, gotData, gotErr);
    checkOutput("illegal_data", 32'(gotData), 32'h00);
    checkOutput("illegal_err", 32'(gotErr), 32'd1);

    waitReady("precedence_wait");
    on        = 1'b0;
    cmd_op    = 3'd4;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("precedence_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("precedence_in_sel", 32'(alu_in_sel), 32'h1);
    on = 1'b1;
    @(negedge clk);
    checkOutput("precedence_ready_again", 32'(cmd_ready), 32'd1);
    checkOutput("precedence_no_rsp", 32'(rsp_valid), 32'd0);
    checkOutput("precedence_count", 32'(op_count), 32'(modelCount));

    for (int i = 0; i < 60; i++) begin
      logic [2:0] rOp;
      logic [7:0] rA;
      logic [7:0] rB;
      rOp = 3'($urandom_range(0, 7));
      rA  = 8'($urandom);
      rB  = 8'($urandom);
      if (rOp == 3'd6 && $urandom_range(0, 1) == 1) begin
        rA = rA & 8'h0F;
        rB = rB & 8'h0F;
      end
      applyStimulus(rOp, rA, rB, 1'($urandom_range(0, 1)), $urandom_range(0, 2), gotData, gotErr);
    end

    waitReady("reset_exec_wait");
    cmd_op    = 3'd4;
    cmd_a     = 8'h21;
    cmd_b     = 8'h42;
    cmd_chain = 1'b0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("reset_exec_load", 32'(alu_in_sel), 32'h2);
    @(negedge clk);
    checkOutput("reset_exec_sel", 32'(alu_out_sel), 32'h4);
    #2;
    rst = 1'b0;
    #1;
    checkResetValues("mid_exec_reset");
    @(negedge clk);
    checkOutput("reset_no_rsp", 32'(rsp_valid), 32'd0);
    rst        = 1'b1;
    modelCount = 8'h00;
    modelAcc   = 8'h00;
    @(negedge clk);
    checkOutput("reset_release_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset_release_no_rsp", 32'(rsp_valid), 32'd0);

    for (int i = 0; i < 256; i++) begin
      applyStimulus(3'd7, 8'h00, 8'h00, 1'b0, 0, gotData, gotErr);
      if (i == 254) begin
        checkOutput("count_ff", 32'(op_count), 32'hFF);
      end
    end
    checkOutput("count_wrap", 32'(op_count), 32'h00);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-driven controller that sequences the 8-bit ALU datapath (operand mux/register stage, logic/arith units, output mux). Accepts one operation per valid/ready command, drives the ALU's operand, input-selector and output-selector lines through load, execute and capture phases, and returns the result with an error flag on a valid/ready response channel. Maintains a result accumulator for chained operations and recovers the datapath after multiply overflow.

## Interface
- No parameters; datapath width fixed at 8.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `on` in 1: enable; sampled in OFF/READY only.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_op` in 3: 0 AND, 1 OR, 2 NOT, 3 XOR, 4 ADD, 5 SUB, 6 MULT, 7 illegal.
- `cmd_chain` in 1: use accumulator as operand A.
- `cmd_a`, `cmd_b` in 8: operands.
- `alu_in_sel` out 3: one-hot {persist, load, reset} to the ALU operand muxes.
- `alu_num1`, `alu_num2` out 8: operands to the ALU.
- `alu_out_sel` out 7: one-hot {and, or, not, xor, add, sub, mult}, MSB = and.
- `alu_result` in 8, `alu_overflow` in 1: from the ALU.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_data` out 8, `rsp_error` out 1: result and error flag.
- `op_count` out 8: completed responses, wraps 0xFF→0x00.

## Operation
- States: OFF, READY, LOAD, EXEC, RESP, ERROR.
- OFF: `cmd_ready`=0, `alu_in_sel`=3'b001; `on`=1 → READY.
- READY: `cmd_ready`=1. `on`=0 → OFF; `on` takes precedence over a same-cycle `cmd_valid` (no accept). On accept, latch op, operands and chain.
- Legal op accepted → LOAD. Op 7 → RESP directly with `rsp_data`=0, `rsp_error`=1; ALU untouched.
- LOAD: `alu_in_sel`=3'b010; `alu_num1` = chain ? acc : latched A; `alu_num2` = latched B. → EXEC.
- EXEC: `alu_in_sel`=3'b100, `alu_out_sel` = 7'b1000000 >> op. On exit, capture `alu_result` into `rsp_data` and acc; `rsp_error` = `alu_overflow` && op==MULT. → RESP.
- RESP: `rsp_valid`=1; outputs stable until `rsp_ready`. On handshake: `op_count`++; if `rsp_error` (MULT overflow) → ERROR, else → READY.
- ERROR: one cycle, `alu_in_sel`=3'b001, acc cleared to 0. → READY.
- `alu_out_sel`=0 outside EXEC; `alu_num1`/`alu_num2` hold their last values.
- `on` deasserted mid-operation: the operation completes; the FSM goes to OFF from READY.
- Arithmetic is mod 256; ADD carry is discarded; SUB wraps; MULT overflow is the only error source besides op 7.

## Timing
- Reset (async assert): state OFF, `cmd_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_error`=0, `alu_in_sel`=3'b001, `alu_out_sel`=0, `alu_num1`=`alu_num2`=0, acc=0, `op_count`=0.
- Reset release: takes effect on the next `clk` edge.
- Reset mid-operation: aborts immediately; no response is issued.
- Legal op: accept at edge k; LOAD in cycle k+1; EXEC in k+2; `rsp_valid` high from cycle k+3.
- Illegal op: `rsp_valid` high in cycle k+1.
- Throughput: one command per 4 cycles minimum (5 with ERROR); `cmd_ready` is low from accept until back in READY.
- All outputs are registered or decoded from the state register; no combinational path from `rsp_ready`/`cmd_valid` to outputs.

## Configuration
- `ALU_SEQ_CHAIN_EN` defined: `cmd_chain` is honoured and the accumulator is implemented.
- Undefined: `cmd_chain` is ignored (treated as 0), acc logic is removed, `alu_num1` is always latched A, and ERROR still drives the reset selector for one cycle.

## Test plan
- Reset, `on`=0 → all outputs at reset values; `on`=1 → `cmd_ready`=1 next cycle.
- ADD A=0x12, B=0x34 → `rsp_valid` 3 cycles after accept, `rsp_data`=0x46, `rsp_error`=0, `alu_out_sel`=7'b0000100 in EXEC.
- MULT 0x10×0x10 (`alu_overflow`=1) → `rsp_error`=1; after handshake, one ERROR cycle with `alu_in_sel`=3'b001; next chained ADD with B=0x01 (CHAIN_EN) → 0x01.
- CHAIN_EN: ADD 0x05+0x03 → 0x08; then chain SUB B=0x0A → 0xFE, `alu_num1`=0x08 in LOAD.
- `rsp_ready` low 4 cycles in RESP → `rsp_valid` and `rsp_data` held, `op_count` increments once; op 7 → `rsp_error`=1, `rsp_data`=0, 1-cycle latency.
- Assert `rst` during EXEC → immediate return to reset values, no response; `op_count` wrap from 0xFF → 0x00 after 256 responses.
